// File: rtl/udp_tx_pkt_sched.sv
// Read-side packet scheduler for the UDP TX data FIFO: launches full or flushed tail packets,
// then streams bytes on request. Optional statistics counters: UDP_TX_PKT_SCHED_STAT_EN.
module udp_tx_pkt_sched #(
  parameter int unsigned PKT_LEN    = 1024,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned LVL_W      = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LVL_W-1:0] fifo_rd_water_level,
  input  logic             fifo_rd_empty,
  input  logic [7:0]       fifo_rd_data,
  output logic             fifo_rd_en,
  input  logic             flush,
  output logic             udp_tx_start,
  output logic [15:0]      udp_tx_byte_num,
  input  logic             udp_tx_req,
  output logic [7:0]       udp_tx_data,
  input  logic             udp_tx_done,
  output logic             busy,
  output logic             underrun_err
`ifdef UDP_TX_PKT_SCHED_STAT_EN
  ,
  output logic [31:0]      pkt_cnt,
  output logic [31:0]      byte_cnt
`endif
);

  localparam logic [LVL_W-1:0] PKT_LEN_LVL = LVL_W'(PKT_LEN);
  localparam logic [15:0]      PKT_LEN_16  = 16'(PKT_LEN);
  localparam logic [7:0]       GAP_8       = 8'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] len;
  logic [15:0] len_next;
  logic [15:0] remain;
  logic [7:0]  gap_cnt;
  logic        flush_pend;
  logic        flush_clr;
  logic        underrun_hit;

  // Handshake: udp_tx_req is a one-cycle request for the next byte; when it is accepted
  // (fifo_rd_en high) the byte appears on udp_tx_data on the following cycle.
  always_comb begin
    state_next      = state;
    len_next        = len;
    flush_clr       = 1'b0;
    udp_tx_start    = 1'b0;
    fifo_rd_en      = 1'b0;
    underrun_hit    = 1'b0;
    busy            = (state != IDLE);
    udp_tx_byte_num = len;
    udp_tx_data     = fifo_rd_data;
    case (state)
      IDLE: begin
        // Full packets win over a pending tail flush.
        if (fifo_rd_water_level >= PKT_LEN_LVL) begin
          len_next   = PKT_LEN_16;
          state_next = START;
        end else if (flush_pend && (fifo_rd_water_level != '0)) begin
          len_next   = 16'(fifo_rd_water_level);
          flush_clr  = 1'b1;
          state_next = START;
        end else if (fifo_rd_water_level == '0) begin
          flush_clr  = 1'b1;
        end
      end
      START: begin
        udp_tx_start = 1'b1;
        state_next   = SEND;
      end
      SEND: begin
        fifo_rd_en   = udp_tx_req && (remain != 16'd0) && !fifo_rd_empty;
        underrun_hit = udp_tx_req && ((remain == 16'd0) || fifo_rd_empty);
        // An early done is an abort by the UDP layer; unread bytes stay queued.
        if (udp_tx_done) state_next = GAP;
      end
      GAP: begin
        if (gap_cnt == 8'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      len          <= 16'd0;
      remain       <= 16'd0;
      gap_cnt      <= 8'd0;
      flush_pend   <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      state <= state_next;
      len   <= len_next;
      if (flush) flush_pend <= 1'b1;
      else if (flush_clr) flush_pend <= 1'b0;
      if (state == START) remain <= len;
      else if (fifo_rd_en) remain <= remain - 16'd1;
      if ((state == SEND) && udp_tx_done) gap_cnt <= GAP_8;
      else if ((state == GAP) && (gap_cnt != 8'd0)) gap_cnt <= gap_cnt - 8'd1;
      if (underrun_hit) underrun_err <= 1'b1;
    end
  end

`ifdef UDP_TX_PKT_SCHED_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt  <= 32'd0;
      byte_cnt <= 32'd0;
    end else begin
      if (state == START) pkt_cnt <= pkt_cnt + 32'd1;
      if (fifo_rd_en) byte_cnt <= byte_cnt + 32'd1;
    end
  end
`else
  // Statistics counters are compiled out in this build.
`endif

endmodule

// File: tb/tb_udp_tx_pkt_sched.sv
// Bench for udp_tx_pkt_sched: FIFO model, packet-plan reference model and byte scoreboard.
module tb_udp_tx_pkt_sched;
  localparam int PKT_LEN      = 1024;
  localparam int GAP_CYCLES   = 16;
  localparam int LVL_W        = 13;
  localparam int START_BUDGET = 400;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [LVL_W-1:0] fifo_rd_water_level = '0;
  logic             fifo_rd_empty = 1'b1;
  logic [7:0]       fifo_rd_data = 8'd0;
  logic             fifo_rd_en;
  logic             flush = 1'b0;
  logic             udp_tx_start;
  logic [15:0]      udp_tx_byte_num;
  logic             udp_tx_req = 1'b0;
  logic [7:0]       udp_tx_data;
  logic             udp_tx_done = 1'b0;
  logic             busy;
  logic             underrun_err;
`ifdef UDP_TX_PKT_SCHED_STAT_EN
  logic [31:0]      pkt_cnt;
  logic [31:0]      byte_cnt;
`endif

  udp_tx_pkt_sched #(.PKT_LEN(PKT_LEN), .GAP_CYCLES(GAP_CYCLES), .LVL_W(LVL_W)) dut (
    .clk(clk), .rst(rst),
    .fifo_rd_water_level(fifo_rd_water_level), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .flush(flush),
    .udp_tx_start(udp_tx_start), .udp_tx_byte_num(udp_tx_byte_num),
    .udp_tx_req(udp_tx_req), .udp_tx_data(udp_tx_data), .udp_tx_done(udp_tx_done),
    .busy(busy), .underrun_err(underrun_err)
`ifdef UDP_TX_PKT_SCHED_STAT_EN
    , .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         plan_q[$];
  bit         exp_underrun = 1'b0;

  // FIFO model: registered read data, level and empty
  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1 && fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
    fifo_rd_water_level <= LVL_W'(fifo_q.size());
    fifo_rd_empty       <= (fifo_q.size() == 0);
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // reference model: packet lengths implied by a level and a flush request
  function automatic void plan_packets(input int level, input bit flushed);
    plan_q.delete();
    while (level >= PKT_LEN) begin
      plan_q.push_back(PKT_LEN);
      level -= PKT_LEN;
    end
    if (flushed && level > 0) plan_q.push_back(level);
  endfunction

  // driver tasks
  task automatic push_bytes(input int n, input bit pattern);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = pattern ? 8'(k) : 8'($urandom);
      fifo_q.push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_start(input string name, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (udp_tx_start !== 1'b1 && waited < START_BUDGET);
    checks++;
    if (udp_tx_start !== 1'b1) begin
      errors++;
      $display("FAIL %s start_seen: got udp_tx_start=%b want 1 within %0d cycles", name, udp_tx_start, START_BUDGET);
    end
  endtask

  task automatic no_start_window(input string name, input int cycles);
    int seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (udp_tx_start === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL %s no_start: got %0d start pulses want 0", name, seen);
    end
  endtask

  // acts as the UDP layer: called at the negedge where udp_tx_start is high
  task automatic serve_packet(input string name, input int exp_len, input int n_req);
    int         issued = 0;
    int         rd_seen = 0;
    int         busy_bad = 0;
    int         want_rd;
    bit         exp_rd;
    logic [7:0] exp_b;
    checks++;
    if (udp_tx_byte_num !== 16'(exp_len)) begin
      errors++;
      $display("FAIL %s byte_num: got %0d want %0d", name, udp_tx_byte_num, exp_len);
    end
    @(negedge clk);
    checks++;
    if (udp_tx_start !== 1'b0) begin
      errors++;
      $display("FAIL %s start_width: got udp_tx_start=%b want 0", name, udp_tx_start);
    end
    while (issued < n_req) begin
      if ($urandom_range(0, 3) == 0) begin
        udp_tx_req = 1'b0;
        exp_rd = 1'b0;
      end else begin
        udp_tx_req = 1'b1;
        issued++;
        exp_rd = (issued <= exp_len);
        if (!exp_rd) exp_underrun = 1'b1;
      end
      #1;
      checks++;
      if (fifo_rd_en !== exp_rd) begin
        errors++;
        $display("FAIL %s rd_en: req %0d got %b want %b", name, issued, fifo_rd_en, exp_rd);
      end
      if (fifo_rd_en === 1'b1) rd_seen++;
      @(negedge clk);
      if (exp_rd) begin
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (udp_tx_data !== exp_b) begin
          errors++;
          $display("FAIL %s data: byte %0d got %h want %h", name, issued, udp_tx_data, exp_b);
        end
      end
    end
    udp_tx_req = 1'b0;
    want_rd = (n_req < exp_len) ? n_req : exp_len;
    checks++;
    if (rd_seen != want_rd) begin
      errors++;
      $display("FAIL %s rd_count: got %0d want %0d", name, rd_seen, want_rd);
    end
    checks++;
    if (underrun_err !== exp_underrun) begin
      errors++;
      $display("FAIL %s underrun_err: got %b want %b", name, underrun_err, exp_underrun);
    end
    checks++;
    if (udp_tx_byte_num !== 16'(exp_len)) begin
      errors++;
      $display("FAIL %s byte_num_hold: got %0d want %0d", name, udp_tx_byte_num, exp_len);
    end
    udp_tx_done = 1'b1;
    @(negedge clk);
    udp_tx_done = 1'b0;
    for (int k = 1; k <= GAP_CYCLES + 1; k++) begin
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s busy_gap: got %0d idle cycles in gap want 0", name, busy_bad);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_drop: got busy=%b want 0 at %0d cycles after done", name, busy, GAP_CYCLES + 1);
    end
  endtask

  task automatic serve_plan(input string name);
    int waited;
    int len;
    while (plan_q.size() > 0) begin
      len = plan_q.pop_front();
      wait_start(name, waited);
      serve_packet(name, len, len);
    end
  endtask

  // scenario tasks
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (udp_tx_start !== 1'b0) begin errors++; $display("FAIL reset start: got %b want 0", udp_tx_start); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset rd_en: got %b want 0", fifo_rd_en); end
    checks++; if (udp_tx_byte_num !== 16'd0) begin errors++; $display("FAIL reset byte_num: got %0d want 0", udp_tx_byte_num); end
    checks++; if (underrun_err !== 1'b0) begin errors++; $display("FAIL reset underrun: got %b want 0", underrun_err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_packet();
    int waited;
    push_bytes(PKT_LEN, 1'b1);
    wait_start("full", waited);
    serve_packet("full", PKT_LEN, PKT_LEN);
  endtask

  task automatic test_tail_flush();
    int waited;
    push_bytes(300, 1'b0);
    pulse_flush();
    wait_start("tail300", waited);
    serve_packet("tail300", 300, 300);
    pulse_flush();
    no_start_window("tail_empty_flush", 40);
    push_bytes(10, 1'b0);
    no_start_window("tail_stale_flush", 40);
    pulse_flush();
    wait_start("tail10", waited);
    serve_packet("tail10", 10, 10);
  endtask

  task automatic test_priority();
    push_bytes(2100, 1'b0);
    pulse_flush();
    plan_packets(2100, 1'b1);
    serve_plan("priority");
  endtask

  task automatic test_random_mix();
    int  lvl = 0;
    int  n;
    bit  fl;
    for (int it = 0; it < 3; it++) begin
      n  = $urandom_range(1, 2500);
      fl = 1'($urandom_range(0, 1));
      push_bytes(n, 1'b0);
      lvl += n;
      if (fl) pulse_flush();
      plan_packets(lvl, fl);
      serve_plan("random_mix");
      lvl = fl ? 0 : (lvl % PKT_LEN);
    end
    if (lvl > 0) begin
      pulse_flush();
      plan_packets(lvl, 1'b1);
      serve_plan("random_drain");
    end
  endtask

  task automatic test_underrun();
    int waited;
    push_bytes(300, 1'b0);
    pulse_flush();
    wait_start("underrun", waited);
    serve_packet("underrun", 300, 301);
  endtask

  task automatic test_gap_abort();
    int waited;
    push_bytes(2 * PKT_LEN, 1'b0);
    wait_start("abort", waited);
    serve_packet("abort", PKT_LEN, 100);
    wait_start("after_abort", waited);
    checks++;
    if (waited != 1) begin
      errors++;
      $display("FAIL gap_restart: got start %0d cycles after gap end want 1 (GAP_CYCLES+2 after done)", waited);
    end
    serve_packet("after_abort", PKT_LEN, PKT_LEN);
    pulse_flush();
    plan_packets(PKT_LEN - 100, 1'b1);
    serve_plan("abort_tail");
  endtask

  task automatic test_reset_mid_send();
    int waited;
    push_bytes(PKT_LEN, 1'b0);
    wait_start("rst_mid", waited);
    @(negedge clk);
    udp_tx_req = 1'b1;
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL rst_mid rd_en_before: got %b want 1", fifo_rd_en); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_mid rd_en: got %b want 0", fifo_rd_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy: got %b want 0", busy); end
    checks++; if (udp_tx_byte_num !== 16'd0) begin errors++; $display("FAIL rst_mid byte_num: got %0d want 0", udp_tx_byte_num); end
    checks++; if (underrun_err !== 1'b0) begin errors++; $display("FAIL rst_mid underrun: got %b want 0", underrun_err); end
    udp_tx_req = 1'b0;
    exp_underrun = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_start("rst_restart", waited);
    serve_packet("rst_restart", PKT_LEN, PKT_LEN);
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_tail_flush();
    test_priority();
    test_underrun();
    test_random_mix();
    test_gap_abort();
    test_reset_mid_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
